adc_capture: RTL
================

Name: adc_capture

Overview:
- Acquisition block: the receive-side counterpart of the DAC waveform generator.
- Clocks the ADC and registers 14-bit samples, with optional decimation.
- Keeps a pre-trigger history in a circular buffer, detects a level/slope trigger and completes a DEPTH-sample record.
- Streams the record out over a valid/ready interface for the host/display path; the generator loops back into it for self-test.

Parameters:
DW, 14, sample width (matches DAC/ADC word).
AW, 10, buffer address width; DEPTH = 2^AW samples.
PRE, 256, pre-trigger samples; legal range 1..DEPTH-1.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst_n  in  1  synchronous active-low reset.
AD_A  in  DW  ADC parallel data.
AD_CLK_A  out  1  ADC sample clock; equals clk.
arm  in  1  one-cycle pulse; starts a capture from IDLE.
force_trig  in  1  immediate trigger while ARMED.
trig_level  in  DW  trigger threshold, unsigned; latched on arm.
trig_slope  in  1  0 = rising, 1 = falling; latched on arm.
decim  in  8  keep 1 of (decim+1) samples; latched on arm.
busy  out  1  high in PRE/ARMED/POST.
triggered  out  1  high from trigger until return to IDLE.
rd_data  out  DW  readout sample.
rd_valid  out  1  rd_data valid.
rd_ready  in  1  consumer accepts when high with rd_valid.
rd_last  out  1  high with the final (DEPTH-th) readout word.

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; busy, triggered, rd_valid and rd_last = 0; rd_data = 0; pointers, counters and decimation counter = 0. Buffer RAM is not cleared. Reset mid-capture or mid-readout aborts immediately; a partial stream is never resumed.
- Input path: AD_A is registered once into s_cur. The previous kept sample is held in s_prev. Capture latency from AD_A to RAM write is 2 cycles.
- Decimation: dec_cnt counts 0..decim_l. The strobe asserts when dec_cnt == decim_l, then dec_cnt returns to 0. decim=0 strobes every cycle. dec_cnt is cleared on arm.
- All RAM writes, trigger checks and state counters advance only on strobe cycles.
- Write pointer wptr wraps modulo DEPTH.
- FSM states: IDLE, PRE, ARMED, POST, READ.
  - IDLE: arm=1 latches trig_level, trig_slope and decim; clears wptr and the sample count; goes to PRE. arm in any other state is ignored.
  - PRE: writes samples. Triggers are ignored. After exactly PRE writes, goes to ARMED.
  - ARMED: keeps writing circularly. A trigger on a strobe writes that sample, records trig_ptr = its address, sets triggered and goes to POST.
    - Rising trigger: s_prev < level and s_cur >= level.
    - Falling trigger: s_prev > level and s_cur <= level.
    - force_trig: counts regardless of strobe; the next strobe sample becomes the trigger sample.
    - Level trigger and force_trig in the same cycle produce one trigger only.
  - POST: writes DEPTH-PRE-1 further samples, then goes to READ; busy falls on entry to READ.
  - READ: start address = (trig_ptr - PRE) mod DEPTH. Streams DEPTH words in buffer order, so the trigger sample is word index PRE (0-based).
    - rd_valid first asserts within 2 cycles of entering READ.
    - While rd_valid=1 and rd_ready=0, rd_data and rd_last are held stable.
    - Each handshake advances one word; back-to-back transfers at 1 word/cycle with rd_ready held high.
    - rd_last asserts with word DEPTH-1.
    - The handshake of the last word returns to IDLE next cycle: rd_valid=0, triggered=0.
- Arithmetic: all pointer math is modulo 2^AW. Comparisons are unsigned DW-bit.
- No trigger: the block stays in ARMED indefinitely; only reset or force_trig exits.

Test Plan:
- Ramp: drive AD_A = cycle count mod 2^14; trig_level=1000, rising, decim=0, arm → rd_data word 256 = 1000, word 0 = 744, word 1023 = 1767; rd_last only on word 1023.
- Generator loopback, square wave 0/16383 from the DAC generator: trig_level=8192, falling → word 256 = 0, word 255 = 16383; triggered=1 through readout.
- Decimation: ramp input, decim=3 → consecutive readout words differ by 4. Also check trigger-in-PRE suppression: a level crossing during the first 256 strobes causes no trigger.
- Backpressure: toggle rd_ready pseudo-randomly → exactly 1024 transfers, each value correct and held while stalled, no duplicates; afterwards busy=0, rd_valid=0.
- Force/simultaneous/reset:
  - Constant input with force_trig → capture completes with all words equal.
  - force_trig together with a level crossing → a single record.
  - rst_n=0 mid-POST, then a new arm → a clean full record with correct ordering.

Source files
------------

// File: rtl/adc_capture.sv
// adc_capture: ADC acquisition with optional decimation, a circular
// pre-trigger history, level/slope/forced trigger and a valid/ready readout
// of one DEPTH-sample record. The trigger sample is word PRE of the record.
module adc_capture #(
    parameter int DW  = 14,
    parameter int AW  = 10,
    parameter int PRE = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] AD_A,
    output logic          AD_CLK_A,
    input  logic          arm,
    input  logic          force_trig,
    input  logic [DW-1:0] trig_level,
    input  logic          trig_slope,
    input  logic [7:0]    decim,
    output logic          busy,
    output logic          triggered,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic          rd_last
);

    localparam int DEPTH  = 1 << AW;
    localparam int POST_N = DEPTH - PRE - 1;

    // Counter end values: PRE writes before arming, POST_N writes after the trigger.
    localparam logic [AW-1:0] PRE_LAST  = AW'(PRE - 1);
    localparam logic [AW-1:0] POST_LAST = AW'(POST_N - 1);
    localparam logic [AW-1:0] PRE_OFS   = AW'(PRE);
    localparam logic [AW-1:0] WORD_PEN  = AW'(DEPTH - 2);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_ARMED = 3'd2;
    localparam logic [2:0] S_POST  = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;

    logic [2:0]    state;
    logic [DW-1:0] s_cur;
    logic [DW-1:0] s_prev;
    logic [DW-1:0] level_l;
    logic          slope_l;
    logic [7:0]    decim_l;
    logic [7:0]    dec_cnt;
    logic [AW-1:0] wptr;
    logic [AW-1:0] cnt;
    logic [AW-1:0] trig_ptr;
    logic          force_pend;
    logic [AW-1:0] rptr;
    logic [AW-1:0] rcnt;
    logic [DW-1:0] mem [DEPTH];

    logic          strobe;
    logic          level_hit;
    logic          trig_now;
    logic          rd_load;
    logic          rd_advance;
    logic [AW-1:0] rd_addr;

    // The ADC is clocked directly by the system clock.
    assign AD_CLK_A = clk;

    assign busy   = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
    assign strobe = busy && (dec_cnt == decim_l);

    // Slope crossing between the previous and the current kept sample.
    assign level_hit = slope_l ? ((s_prev > level_l) && (s_cur <= level_l))
                               : ((s_prev < level_l) && (s_cur >= level_l));

    // A pending force, a force in this very cycle or a level crossing all
    // collapse into one trigger on the strobe sample.
    assign trig_now = (state == S_ARMED) && strobe && (level_hit || force_pend || force_trig);

    // Readout: load word 0 once after entering READ, then advance per handshake.
    // While stalled the read address stays put, so the output word is stable.
    assign rd_load    = (state == S_READ) && !rd_valid;
    assign rd_advance = rd_valid && rd_ready && !rd_last;
    assign rd_addr    = rd_advance ? (rptr + 1'b1) : rptr;

    // Register the ADC word every cycle; remember the previous kept sample on strobes.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values and block ordering cannot change behaviour.
        if (!rst_n) begin
            s_cur  <= '0;
            s_prev <= '0;
        end else begin
            s_cur <= AD_A;
            if (strobe) s_prev <= s_cur;
        end
    end

    // Decimation counter: strobe on decim_l, restart at 0; cleared on arm.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_cnt <= '0;
        end else if ((state == S_IDLE) && arm) begin
            dec_cnt <= '0;
        end else if (busy) begin
            dec_cnt <= strobe ? 8'd0 : dec_cnt + 8'd1;
        end
    end

    // Sample buffer write port: every strobe stores s_cur at wptr.
    always_ff @(posedge clk) begin
        // NOTE: the buffer RAM has no reset; a record is always fully rewritten
        // before it is read, and a reset port would prevent block-RAM mapping.
        if (strobe) mem[wptr] <= s_cur;
    end

    // Sample buffer read port, registered; cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_load || rd_advance) begin
            rd_data <= mem[rd_addr];
        end
    end

    // Capture / readout sequencer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            level_l    <= '0;
            slope_l    <= 1'b0;
            decim_l    <= '0;
            wptr       <= '0;
            cnt        <= '0;
            trig_ptr   <= '0;
            force_pend <= 1'b0;
            triggered  <= 1'b0;
            rptr       <= '0;
            rcnt       <= '0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arm) begin
                        level_l    <= trig_level;
                        slope_l    <= trig_slope;
                        decim_l    <= decim;
                        wptr       <= '0;
                        cnt        <= '0;
                        force_pend <= 1'b0;
                        state      <= S_PRE;
                    end
                end
                S_PRE: begin
                    if (strobe) begin
                        wptr <= wptr + 1'b1;
                        if (cnt == PRE_LAST) begin
                            cnt   <= '0;
                            state <= S_ARMED;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_ARMED: begin
                    if (trig_now) begin
                        trig_ptr   <= wptr;
                        wptr       <= wptr + 1'b1;
                        triggered  <= 1'b1;
                        force_pend <= 1'b0;
                        cnt        <= '0;
                        if (POST_N == 0) begin
                            rptr  <= wptr - PRE_OFS;
                            state <= S_READ;
                        end else begin
                            state <= S_POST;
                        end
                    end else begin
                        if (strobe) wptr <= wptr + 1'b1;
                        if (force_trig) force_pend <= 1'b1;
                    end
                end
                S_POST: begin
                    if (strobe) begin
                        wptr <= wptr + 1'b1;
                        if (cnt == POST_LAST) begin
                            rptr  <= trig_ptr - PRE_OFS;
                            state <= S_READ;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (!rd_valid) begin
                        rd_valid <= 1'b1;
                        rd_last  <= 1'b0;
                        rcnt     <= '0;
                    end else if (rd_ready) begin
                        if (rd_last) begin
                            rd_valid  <= 1'b0;
                            rd_last   <= 1'b0;
                            triggered <= 1'b0;
                            state     <= S_IDLE;
                        end else begin
                            rptr    <= rptr + 1'b1;
                            rcnt    <= rcnt + 1'b1;
                            rd_last <= (rcnt == WORD_PEN);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
